// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, logic-unit opcodes and result status flags.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] LU_NOT_A = 3'b000;
    localparam logic [SEL_W-1:0] LU_NOT_B = 3'b001;
    localparam logic [SEL_W-1:0] LU_AND   = 3'b010;
    localparam logic [SEL_W-1:0] LU_OR    = 3'b011;
    localparam logic [SEL_W-1:0] LU_XOR   = 3'b100;
    localparam logic [SEL_W-1:0] LU_XNOR  = 3'b101;
    localparam logic [SEL_W-1:0] LU_NAND  = 3'b110;
    localparam logic [SEL_W-1:0] LU_NOR   = 3'b111;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } lu_flags_t;

    // One buffered result: opcode, flags captured at write time, result word.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        lu_flags_t         flags;
        logic [DATA_W-1:0] res;
    } lu_entry_t;

endpackage

// File: rtl/logic_flag_gen.sv
// Status flags of a result word; shared by the logic and arithmetic result paths.
module logic_flag_gen
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] res_i,
    output lu_flags_t         flags_c
);

    always_comb begin
        flags_c        = '0;
        flags_c.zero   = (res_i == '0);
        flags_c.neg    = res_i[DATA_W-1];
        flags_c.parity = ^res_i;
    end

endmodule

// File: rtl/logic_result_fifo.sv
// Result buffer between the logic unit and a stallable consumer; flags are stored per entry.
module logic_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_res,
    input  logic [SEL_W-1:0]           in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_res,
    output logic [SEL_W-1:0]           out_sel,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_parity,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [7:0]                 push_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    lu_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [7:0]       push_cnt_q, push_cnt_d;

    logic      push;
    logic      pop;
    lu_flags_t in_flags;
    lu_entry_t wr_entry;
    lu_entry_t head;

    logic_flag_gen u_flag_gen (
        .res_i   (in_res),
        .flags_c (in_flags)
    );

    // Handshake status comes only from the registered occupancy.
    assign in_ready  = (occ_q != CNT_W'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_entry       = '0;
        wr_entry.sel   = in_sel;
        wr_entry.flags = in_flags;
        wr_entry.res   = in_res;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push_cnt_d = push_cnt_q;
        occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            push_cnt_d = push_cnt_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            push_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            push_cnt_q <= push_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Empty FIFO presents zeros rather than stale memory.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign out_res    = head.res;
    assign out_sel    = head.sel;
    assign out_zero   = head.flags.zero;
    assign out_neg    = head.flags.neg;
    assign out_parity = head.flags.parity;
    assign occupancy  = occ_q;
    assign push_count = push_cnt_q;

endmodule
